// File: rtl/muldiv_seq_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
//   clogb2        : ceil(log2(value)), usable in parameter expressions
//   muldiv_op_t   : request opcodes; encodings 6 and 7 are ignored by the unit
//   muldiv_state_t: sequencer states
package muldiv_seq_pkg;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MADD = 3'd1,
    OP_MSUB = 3'd2,
    OP_DIV  = 3'd3,
    OP_MTHI = 3'd4,
    OP_MTLO = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIN
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration, purely combinational.
//   rem_in       : partial remainder (always < divisor, or < 2^k when divisor is 0)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module muldiv_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // Because rem_in < divisor, a successful trial subtract always leaves the
  // top bit clear, so that bit alone acts as the borrow.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[DATA_WIDTH];
    rem_out = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
//   clock, reset_n      : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake; req_ready is high only when idle
//   req_op, req_u       : opcode, 1 = unsigned operands
//   req_a, req_b        : operands (req_a is the dividend)
//   kill                : squash the in-flight operation, blocks acceptance
//   busy                : operation in flight (~req_ready)
//   done, div_zero      : one-cycle completion pulse, divisor-was-zero flag
//   hi, lo              : committed HI/LO registers
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_BITS   = 4,
  parameter int unsigned CNT_WIDTH  = clogb2(DATA_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  muldiv_op_t            req_op,
  input  logic                  req_u,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MUL_ITERS = CNT_WIDTH'(W / MUL_BITS);
  localparam logic [CNT_WIDTH-1:0] DIV_ITERS = CNT_WIDTH'(W);

  muldiv_state_t  state, state_nxt;
  muldiv_op_t     op_q;
  logic           neg_q, rem_neg_q, dz_q;
  logic [W-1:0]   opnd_q;              // |a| for MUL-class, |b| for DIV
  logic [2*W-1:0] prod_q;              // MUL: product; DIV: {remainder, dividend/quotient}
  logic [CNT_WIDTH-1:0] cnt_q;

  logic           accept;
  logic           a_neg, b_neg, b_zero;
  logic [W-1:0]   a_abs, b_abs;
  logic [W+MUL_BITS-1:0] mul_sum;
  logic [2*W-1:0] mul_next, div_next, prod_fix, mul_res;
  logic [W-1:0]   rem_step;
  logic           q_step;
  logic [W-1:0]   div_hi, div_lo;

  assign req_ready = (state == MD_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & ~kill;

  always_comb begin
    a_neg  = ~req_u & req_a[W-1];
    b_neg  = ~req_u & req_b[W-1];
    a_abs  = a_neg ? -req_a : req_a;
    b_abs  = b_neg ? -req_b : req_b;
    b_zero = (req_b == '0);
  end

  // Shift-add: add |a| * next multiplier digit into the upper half, then
  // drop MUL_BITS consumed multiplier bits off the bottom.
  always_comb begin
    mul_sum  = {{MUL_BITS{1'b0}}, prod_q[2*W-1:W]}
             + ({{MUL_BITS{1'b0}}, opnd_q} * {{W{1'b0}}, prod_q[MUL_BITS-1:0]});
    mul_next = {mul_sum, prod_q[W-1:MUL_BITS]};
  end

  muldiv_div_step #(.DATA_WIDTH(W)) u_div_step (
    .rem_in      (prod_q[2*W-1:W]),
    .dividend_bit(prod_q[W-1]),
    .divisor     (opnd_q),
    .rem_out     (rem_step),
    .q_bit       (q_step)
  );

  assign div_next = {rem_step, prod_q[W-2:0], q_step};

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    case (op_q)
      OP_MADD: mul_res = {hi, lo} + prod_fix;
      OP_MSUB: mul_res = {hi, lo} - prod_fix;
      default: mul_res = prod_fix;
    endcase
    div_lo = neg_q     ? -prod_q[W-1:0]   : prod_q[W-1:0];
    div_hi = rem_neg_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MUL, OP_MADD, OP_MSUB: state_nxt = MD_MUL;
            OP_DIV:                   state_nxt = MD_DIV;
            default:                  state_nxt = MD_IDLE;
          endcase
        end
      end
      MD_MUL, MD_DIV: if (cnt_q == CNT_WIDTH'(1)) state_nxt = MD_FIN;
      MD_FIN:         state_nxt = MD_IDLE;
      default:        state_nxt = MD_IDLE;
    endcase
    if (kill && state != MD_IDLE) state_nxt = MD_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_MUL, OP_MADD, OP_MSUB: begin
                op_q      <= req_op;
                opnd_q    <= a_abs;
                prod_q    <= {{W{1'b0}}, b_abs};
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= 1'b0;
                dz_q      <= 1'b0;
                cnt_q     <= MUL_ITERS;
              end
              OP_DIV: begin
                // A zero divisor runs the raw dividend with no sign fix-up:
                // the restoring steps then yield all-ones and the dividend.
                op_q      <= req_op;
                opnd_q    <= b_abs;
                prod_q    <= {{W{1'b0}}, (b_zero ? req_a : a_abs)};
                neg_q     <= ~b_zero & (a_neg ^ b_neg);
                rem_neg_q <= ~b_zero & a_neg;
                dz_q      <= b_zero;
                cnt_q     <= DIV_ITERS;
              end
              default: ;
            endcase
          end
        end
        MD_MUL: begin
          prod_q <= mul_next;
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
        end
        MD_DIV: begin
          prod_q <= div_next;
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
        end
        MD_FIN: begin
          if (!kill) begin
            if (op_q == OP_DIV) begin
              hi <= div_hi;
              lo <= div_lo;
            end else begin
              {hi, lo} <= mul_res;
            end
            done     <= 1'b1;
            div_zero <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative, multi-cycle HI/LO multiply/divide unit for the EX stage. It is the parametrised successor to the stage's behavioural `*`, `/` and `%` operators. It uses a radix-2^MUL_BITS shift-add multiplier and a radix-2 restoring divider, and owns the architectural HI/LO registers. It adds a valid/ready handshake, MSUB, kill (squash on redirect) and defined divide-by-zero and overflow results. EX holds the pipeline while `busy` is high and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `DATA_WIDTH`, 32: operand width; HI and LO are each this wide; must be even.
- `MUL_BITS`, 4: multiplier bits retired per cycle; must divide `DATA_WIDTH`.
- `CNT_WIDTH`, `clogb2(DATA_WIDTH)+1`: width of the iteration counter.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit is idle and can accept a request.
- `req_op`  in  `muldiv_op_t`  OP_MUL, OP_MADD, OP_MSUB, OP_DIV, OP_MTHI, OP_MTLO; any other value is ignored.
- `req_u`  in  1  1 = unsigned operands, 0 = signed operands.
- `req_a`, `req_b`  in  `DATA_WIDTH`  operands, already forwarded by EX; `req_a` is the dividend.
- `kill`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in flight; equals `~req_ready`.
- `done`  out  1  one-cycle pulse in the cycle the new `hi`/`lo` are first visible.
- `div_zero`  out  1  valid with `done`: the divisor was 0.
- `hi`, `lo`  out  `DATA_WIDTH`  committed HI and LO registers.

## Operation
- A request is accepted at a rising edge where `req_valid & req_ready & ~kill`.
- On acceptance the unit latches the op, the signedness, the operand absolute values (signed ops only), the result sign and the counter.
- MTHI or MTLO: written into `hi` or `lo` at the accepting edge. The unit stays in IDLE and does not pulse `done`.
- States:
  - IDLE → MUL (OP_MUL, OP_MADD, OP_MSUB) or DIV (OP_DIV).
  - MUL: `DATA_WIDTH/MUL_BITS` iterations; each adds |a|·(low MUL_BITS bits of the multiplier) into the upper half of a 2W product register, then shifts the register right by MUL_BITS.
  - DIV: `DATA_WIDTH` iterations of one restoring step (shift, trial subtract, set quotient bit).
  - Both MUL and DIV go to FIN when the counter reaches zero.
  - FIN: applies the sign fix-up (2W negate for MUL; for DIV, quotient sign = sign(a) xor sign(b) and remainder sign = sign(a)). It then writes `hi`/`lo`, sets `done`, and returns to IDLE.
- Results written at FIN:
  - MUL: {hi,lo} = product.
  - MADD: {hi,lo} += product, modulo 2^2W.
  - MSUB: {hi,lo} −= product, modulo 2^2W.
  - DIV: lo = quotient, hi = remainder; the quotient truncates toward zero.
- Divisor = 0: lo = all ones, hi = `req_a` unmodified (no sign fix-up), `div_zero` = 1. Same result for signed and unsigned.
- Signed most-negative / −1: lo = most negative value, hi = 0. No flag.
- `kill` while busy: the next edge returns the unit to IDLE; `hi`/`lo` are untouched and there is no `done`.
- `kill` at the FIN edge: kill wins and there is no write.
- `kill` in IDLE blocks acceptance.
- Reset mid-operation: returns to IDLE with all outputs at their reset values.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
- Accept edge E0; iterations on edges E1..EN; FIN edge E(N+1).
  - MUL-class ops: N = W/MUL_BITS, so 9 edges at the defaults.
  - DIV: N = W, so 33 edges at the defaults.
- `done` and the new `hi`/`lo` are visible in the cycle after E(N+1). `req_ready` is high in that same cycle, so back-to-back requests are accepted there.
- `req_ready` is registered. No combinational path from `req_*` or `kill` to any output.
- MTHI/MTLO: 1-cycle latency, no stall.
- EX must stall MFHI/MFLO while `busy`. `hi`/`lo` never show partial results.

## Structure
- Add to `pipTypes`:
  - `OP_MSUB` in `muldiv_op_t`.
  - `muldiv_state_t` {MD_IDLE, MD_MUL, MD_DIV, MD_FIN}.
- Move the `clogb2` macro into a shared include.
- One sub-module, `muldiv_div_step`: combinational single restoring-divide iteration (partial remainder, divisor → next remainder, quotient bit), parametrised by `DATA_WIDTH`.
- Everything else stays in `muldiv_seq`.

## Test plan
- Unsigned MUL, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 9 cycles after acceptance; `req_ready` low for the cycles in between.
- Signed ops, each starting from {hi,lo}={0,5} where relevant:
  - MUL −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MADD 2 × 3 → lo=11.
  - MSUB 2 × 3 → hi=lo=0xFFFFFFFF.
- Signed DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, `done` after 33 cycles. Unsigned DIV of the same bit patterns → lo=0x7FFFFFFC, hi=1.
- Edge cases:
  - DIV 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234, `div_zero`=1.
  - Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- MTHI 0xA5A5A5A5 accepted → `hi` updates next cycle, no `done`. Then MFHI-style read with `req_valid` low on the following cycle → `hi`=0xA5A5A5A5.
- Aborts:
  - DIV with `kill` pulsed at iteration 5 → no `done`, `hi`/`lo` unchanged, `req_ready`=1 next cycle.
  - `kill` on the FIN edge → no write.
  - `reset_n` low mid-MUL → all outputs return to their reset values asynchronously.
